// File: rtl/traffic_signal_monitor.sv
// Independent conflict/timing monitor for the highway/country light codes.
// Flags conflicting greens, invalid codes, illegal colour steps, short yellow
// and short all-red clearance. It latches the first fault code and requests
// flash mode until the fault is acknowledged or the block is reset.
module traffic_signal_monitor #(
  parameter int unsigned MIN_YELLOW    = 3,
  parameter int unsigned MIN_RED_CLEAR = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic [1:0] highway_road,
  input  logic [1:0] country_road,
  input  logic       ack_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic [7:0] fault_cnt
);

  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] YEL = 2'd1;
  localparam logic [1:0] GRN = 2'd2;
  localparam logic [1:0] INV = 2'd3;

  localparam logic [2:0] CODE_NONE      = 3'd0;
  localparam logic [2:0] CODE_CONFLICT  = 3'd1;
  localparam logic [2:0] CODE_INVALID   = 3'd2;
  localparam logic [2:0] CODE_SKIP_YEL  = 3'd3;
  localparam logic [2:0] CODE_ILL_STEP  = 3'd4;
  localparam logic [2:0] CODE_SHORT_YEL = 3'd5;
  localparam logic [2:0] CODE_SHORT_CLR = 3'd6;

  localparam logic [CNT_W-1:0] MIN_YEL_C = CNT_W'(MIN_YELLOW);
  localparam logic [CNT_W-1:0] MIN_CLR_C = CNT_W'(MIN_RED_CLEAR);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]       prev_hw;
  logic [1:0]       prev_cr;
  logic [CNT_W-1:0] yel_cnt_hw;
  logic [CNT_W-1:0] yel_cnt_cr;
  logic [CNT_W-1:0] allred_cnt;

  logic [3:0] flags_hw_c;
  logic [3:0] flags_cr_c;
  logic [2:0] viol_code_c;
  logic       viol_c;

  // Per-road transition flags {short_clear, short_yellow, illegal_step, skipped_yellow};
  // transitions touching the invalid code are left to the invalid check.
  function automatic logic [3:0] road_flags(
    input logic [1:0]       prev,
    input logic [1:0]       cur,
    input logic [CNT_W-1:0] yel_cnt,
    input logic [CNT_W-1:0] ar_cnt
  );
    logic [3:0] f;
    f = 4'b0000;
    if (prev != INV && cur != INV) begin
      f[0] = (prev == GRN) && (cur == RED);
      f[1] = ((prev == RED) && (cur == YEL)) || ((prev == YEL) && (cur == GRN));
      f[2] = (prev == YEL) && (cur == RED) && (yel_cnt < MIN_YEL_C);
      f[3] = (prev == RED) && (cur == GRN) && (ar_cnt < MIN_CLR_C);
    end
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Violation detection with fixed priority: lowest code wins.
  always_comb begin
    flags_hw_c  = road_flags(prev_hw, highway_road, yel_cnt_hw, allred_cnt);
    flags_cr_c  = road_flags(prev_cr, country_road, yel_cnt_cr, allred_cnt);
    viol_code_c = CODE_NONE;
    if (highway_road != RED && country_road != RED &&
        highway_road != INV && country_road != INV)
      viol_code_c = CODE_CONFLICT;
    else if (highway_road == INV || country_road == INV)
      viol_code_c = CODE_INVALID;
    else if (flags_hw_c[0] || flags_cr_c[0])
      viol_code_c = CODE_SKIP_YEL;
    else if (flags_hw_c[1] || flags_cr_c[1])
      viol_code_c = CODE_ILL_STEP;
    else if (flags_hw_c[2] || flags_cr_c[2])
      viol_code_c = CODE_SHORT_YEL;
    else if (flags_hw_c[3] || flags_cr_c[3])
      viol_code_c = CODE_SHORT_CLR;
    viol_c = (viol_code_c != CODE_NONE);
  end

  // History and saturating yellow/all-red counters; all-red preset so the first green is legal.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      prev_hw    <= RED;
      prev_cr    <= RED;
      yel_cnt_hw <= '0;
      yel_cnt_cr <= '0;
      allred_cnt <= MIN_CLR_C;
    end else begin
      prev_hw    <= highway_road;
      prev_cr    <= country_road;
      yel_cnt_hw <= (highway_road == YEL) ? sat_inc(yel_cnt_hw) : '0;
      yel_cnt_cr <= (country_road == YEL) ? sat_inc(yel_cnt_cr) : '0;
      allred_cnt <= (highway_road == RED && country_road == RED) ? sat_inc(allred_cnt) : '0;
    end
  end

  // Fault latch: first code held; ack clears only on a violation-free cycle.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
    end else if (viol_c) begin
      if (!fault || ack_fault) begin
        fault      <= 1'b1;
        fault_code <= viol_code_c;
      end
    end else if (ack_fault) begin
      fault      <= 1'b0;
      fault_code <= CODE_NONE;
    end
  end

  // Saturating count of cycles with any violation present.
  always_ff @(posedge clk) begin
    if (!clear_n)
      fault_cnt <= 8'd0;
    else if (viol_c && fault_cnt != 8'hFF)
      fault_cnt <= fault_cnt + 8'd1;
  end

  assign flash = fault;

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Directed and randomized bench for traffic_signal_monitor against a
// behavioural model built from the monitor's rules.
module tb_traffic_signal_monitor;

  localparam int MIN_YELLOW    = 3;
  localparam int MIN_RED_CLEAR = 2;
  localparam int CNT_SAT       = 15;

  logic       clk = 1'b0;
  logic       clear_n;
  logic [1:0] highway_road;
  logic [1:0] country_road;
  logic       ack_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash;
  logic [7:0] fault_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ph, m_pc, m_yh, m_yc, m_ar, m_fault, m_code, m_cnt;

  traffic_signal_monitor #(
    .MIN_YELLOW(MIN_YELLOW), .MIN_RED_CLEAR(MIN_RED_CLEAR), .CNT_W(4)
  ) dut (
    .clk(clk), .clear_n(clear_n), .highway_road(highway_road),
    .country_road(country_road), .ack_fault(ack_fault), .fault(fault),
    .fault_code(fault_code), .flash(flash), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Lowest transition-rule code (3..6) for one road, 7 when none applies.
  function automatic int road_rule(input int p, input int x, input int y, input int ar);
    if (p == 3 || x == 3) return 7;
    if (p == 2 && x == 0) return 3;
    if ((p == 0 && x == 1) || (p == 1 && x == 2)) return 4;
    if (p == 1 && x == 0 && y < MIN_YELLOW) return 5;
    if (p == 0 && x == 2 && ar < MIN_RED_CLEAR) return 6;
    return 7;
  endfunction

  function automatic int model_viol(input int h, input int c);
    int r;
    if (h != 0 && c != 0 && h != 3 && c != 3) return 1;
    if (h == 3 || c == 3) return 2;
    r = min_i(road_rule(m_ph, h, m_yh, m_ar), road_rule(m_pc, c, m_yc, m_ar));
    return (r == 7) ? 0 : r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_pc = 0; m_yh = 0; m_yc = 0; m_ar = MIN_RED_CLEAR;
    m_fault = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input int h, input int c, input int a, input int rn);
    int v;
    if (rn == 0) begin
      model_reset();
      return;
    end
    v = model_viol(h, c);
    if (v != 0) begin
      m_cnt = min_i(m_cnt + 1, 255);
      if (m_fault == 0 || a != 0) begin
        m_fault = 1;
        m_code  = v;
      end
    end else if (a != 0) begin
      m_fault = 0;
      m_code  = 0;
    end
    m_yh = (h == 1) ? min_i(m_yh + 1, CNT_SAT) : 0;
    m_yc = (c == 1) ? min_i(m_yc + 1, CNT_SAT) : 0;
    m_ar = (h == 0 && c == 0) ? min_i(m_ar + 1, CNT_SAT) : 0;
    m_ph = h;
    m_pc = c;
  endtask

  // Drive one cycle at the falling edge, then compare all outputs after the rising edge.
  task automatic step(input int h, input int c, input int a, input int rn);
    @(negedge clk);
    highway_road = 2'(h);
    country_road = 2'(c);
    ack_fault    = a[0];
    clear_n      = rn[0];
    model_edge(h, c, a, rn);
    @(posedge clk);
    #1;
    check("fault", int'(fault), m_fault);
    check("fault_code", int'(fault_code), m_code);
    check("flash", int'(flash), m_fault);
    check("fault_cnt", int'(fault_cnt), m_cnt);
  endtask

  task automatic hold(input int h, input int c, input int n);
    for (int i = 0; i < n; i++) step(h, c, 0, 1);
  endtask

  initial begin
    int h, c, a, rn;
    clear_n = 1'b0; highway_road = 2'd0; country_road = 2'd0; ack_fault = 1'b0;
    model_reset();

    // Reset state
    step(0, 0, 0, 0);
    check("reset_fault", int'(fault), 0);
    check("reset_code", int'(fault_code), 0);
    check("reset_cnt", int'(fault_cnt), 0);

    // Legal full cycle
    hold(2, 0, 5); hold(1, 0, 3); hold(0, 0, 2); hold(0, 2, 4);
    hold(0, 1, 3); hold(0, 0, 2); hold(2, 0, 1);
    check("legal_fault", int'(fault), 0);
    check("legal_cnt", int'(fault_cnt), 0);

    // Conflict latches code 1 and holds while the count rises
    hold(2, 2, 1);
    check("conflict_code", int'(fault_code), 1);
    check("conflict_cnt", int'(fault_cnt), 1);
    hold(2, 2, 3);
    check("conflict_hold_code", int'(fault_code), 1);
    check("conflict_hold_cnt", int'(fault_cnt), 4);

    // Ack while violating keeps fault; recover to all-red then ack clears
    step(2, 2, 1, 1);
    check("ack_viol_fault", int'(fault), 1);
    hold(0, 0, 2);
    step(0, 0, 1, 1);
    check("ack_clear_fault", int'(fault), 0);
    check("ack_clear_code", int'(fault_code), 0);
    check("ack_clear_cnt", int'(fault_cnt), 6);

    // Short yellow
    step(0, 0, 0, 0);
    hold(2, 0, 3); hold(1, 0, 2); hold(0, 0, 1);
    check("short_yellow", int'(fault_code), 5);

    // Skipped yellow
    step(0, 0, 0, 0);
    hold(2, 0, 2); hold(0, 0, 1);
    check("skip_yellow", int'(fault_code), 3);

    // Invalid beats skipped yellow; later short clearance does not overwrite
    step(0, 0, 0, 0);
    hold(2, 0, 2); hold(0, 3, 1);
    check("invalid_prio", int'(fault_code), 2);
    hold(0, 2, 1);
    check("invalid_hold", int'(fault_code), 2);

    // Reset mid-fault with ack and conflict present
    step(0, 0, 0, 0);
    hold(2, 0, 3); hold(1, 0, 2); hold(0, 0, 1); hold(2, 2, 6);
    check("pre_reset_code", int'(fault_code), 5);
    check("pre_reset_cnt", int'(fault_cnt), 7);
    step(2, 2, 1, 0);
    check("rst_fault", int'(fault), 0);
    check("rst_code", int'(fault_code), 0);
    check("rst_cnt", int'(fault_cnt), 0);
    hold(2, 0, 1);
    check("post_reset_green", int'(fault), 0);

    // Randomized walk: mostly holding codes, occasional ack and reset
    h = 2; c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 30) begin
        h = int'($urandom_range(3));
        c = ($urandom_range(99) < 60) ? 0 : int'($urandom_range(3));
        if ($urandom_range(1) == 1) begin int t; t = h; h = c; c = t; end
      end
      a  = ($urandom_range(99) < 10) ? 1 : 0;
      rn = ($urandom_range(99) < 2) ? 0 : 1;
      step(h, c, a, rn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
